// File: rtl/ifq.sv
// Instruction fetch queue: fetches 128-bit lines from a combinational i-cache into a
// circular line buffer and hands out one instruction (with its PC) per pop.
module ifq #(
  parameter int unsigned      DATA_WIDTH       = 32,
  parameter int unsigned      CACHE_LINE_WIDTH = 128,
  parameter int unsigned      IFQ_DEPTH        = 4,
  parameter logic [31:0]      RESET_PC         = 32'h0040_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [DATA_WIDTH-1:0]       PC_in,
  output logic                        rd_en,
  output logic                        abort,
  input  logic [CACHE_LINE_WIDTH-1:0] D_out,
  input  logic                        d_out_valid,
  input  logic                        dispatch_rd_en,
  input  logic                        jmp_branch_valid,
  input  logic [DATA_WIDTH-1:0]       jmp_branch_address,
  output logic [DATA_WIDTH-1:0]       instr_out,
  output logic [DATA_WIDTH-1:0]       pc_out,
  output logic                        empty
);

  localparam int unsigned WORDS      = CACHE_LINE_WIDTH / DATA_WIDTH;
  localparam int unsigned OFF_W      = $clog2(WORDS);
  localparam int unsigned LOW_W      = $clog2(IFQ_DEPTH);
  localparam int unsigned PTR_W      = LOW_W + 1;
  localparam logic [DATA_WIDTH-1:0] LINE_BYTES = DATA_WIDTH'(CACHE_LINE_WIDTH / 8);
  localparam logic [DATA_WIDTH-1:0] LINE_MASK  = LINE_BYTES - DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] WORD_BYTES = DATA_WIDTH'(DATA_WIDTH / 8);

  logic [CACHE_LINE_WIDTH-1:0] queue_q [IFQ_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OFF_W-1:0]      rd_offset_q, rd_offset_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] pc_out_q, pc_out_d;

  logic                        full;
  logic                        fill;
  logic                        pop;
  logic [CACHE_LINE_WIDTH-1:0] head_line;

  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[LOW_W-1:0] == rd_ptr_q[LOW_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign PC_in  = fetch_pc_q;
  assign rd_en  = !full && rst_n;
  assign abort  = jmp_branch_valid;
  assign pc_out = pc_out_q;

  // A redirect outranks both the fill and the pop of the same cycle.
  assign fill = rd_en && d_out_valid && !jmp_branch_valid;
  assign pop  = dispatch_rd_en && !empty && !jmp_branch_valid;

  // Head word is gated so an empty queue never exposes stale or uninitialised lines.
  always_comb begin
    head_line = queue_q[rd_ptr_q[LOW_W-1:0]];
    instr_out = '0;
    if (!empty) instr_out = head_line[rd_offset_q*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_offset_d = rd_offset_q;
    fetch_pc_d  = fetch_pc_q;
    pc_out_d    = pc_out_q;

    if (jmp_branch_valid) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      fetch_pc_d  = jmp_branch_address;
      pc_out_d    = jmp_branch_address;
      rd_offset_d = jmp_branch_address[OFF_W+1:2];
    end else begin
      if (fill) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = (fetch_pc_q & ~LINE_MASK) + LINE_BYTES;
      end
      if (pop) begin
        pc_out_d    = pc_out_q + WORD_BYTES;
        rd_offset_d = rd_offset_q + OFF_W'(1);
        if (rd_offset_q == OFF_W'(WORDS - 1)) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_offset_q <= RESET_PC[OFF_W+1:2];
      fetch_pc_q  <= DATA_WIDTH'(RESET_PC);
      pc_out_q    <= DATA_WIDTH'(RESET_PC);
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_offset_q <= rd_offset_d;
      fetch_pc_q  <= fetch_pc_d;
      pc_out_q    <= pc_out_d;
    end
  end

  // NOTE: the line storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (fill) queue_q[wr_ptr_q[LOW_W-1:0]] <= D_out;
  end

endmodule

// File: doc/ifq.md
Name: ifq

Overview:
- Instruction fetch queue sitting directly downstream of `i_cache`. It drives the cache fetch address and read strobe, and buffers the returned 128-bit cache lines in a small circular queue.
- It hands one 32-bit instruction per pop to the dispatch stage, together with that instruction's PC.
- On a taken jump/branch it aborts the in-flight cache read, flushes the queue and redirects fetch to the target.

Parameters:
- DATA_WIDTH, 32, instruction/address width.
- CACHE_LINE_WIDTH, 128, cache line width (4 instructions per line).
- IFQ_DEPTH, 4, number of cache lines held; power of two, ≥2.
- RESET_PC, 32'h0040_0000, fetch and dispatch PC after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PC_in  out  DATA_WIDTH  fetch address to `i_cache`.
- rd_en  out  1  cache read request.
- abort  out  1  cancels the current cache read.
- D_out  in  CACHE_LINE_WIDTH  line returned by `i_cache`.
- d_out_valid  in  1  D_out valid in the same cycle as rd_en (the cache is combinational).
- dispatch_rd_en  in  1  dispatch pops one instruction.
- jmp_branch_valid  in  1  redirect request.
- jmp_branch_address  in  DATA_WIDTH  redirect target, word aligned.
- instr_out  out  DATA_WIDTH  instruction at the head of the queue.
- pc_out  out  DATA_WIDTH  PC of instr_out.
- empty  out  1  no instruction available.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC, pc_out=RESET_PC.
  - wr_ptr=rd_ptr=0; each pointer is log2(IFQ_DEPTH)+1 bits, with the extra bit used as the wrap bit.
  - rd_offset=RESET_PC[3:2].
  - empty=1, instr_out is don't-care (driven 0), rd_en=0 while rst_n=0.
  - Reset mid-fill or mid-flush discards everything.
- Status flags:
  - full = (wr_ptr[MSB]!=rd_ptr[MSB]) && (wr_ptr[low]==rd_ptr[low]).
  - empty = (wr_ptr==rd_ptr).
- Fetch side:
  - PC_in=fetch_pc.
  - rd_en = !full && rst_n.
  - abort = jmp_branch_valid (combinational).
- Line write: when rd_en && d_out_valid && !abort, on the clock edge:
  - queue[wr_ptr[low]] <= D_out;
  - wr_ptr++;
  - fetch_pc <= {fetch_pc[31:4]+1, 4'b0}, which realigns to the next line.
- Word order: instruction k of a line is D_out[32k+31:32k], with k = address bits [3:2].
- Dispatch side:
  - instr_out = queue[rd_ptr[low]] word rd_offset (combinational).
  - Pop occurs when dispatch_rd_en && !empty && !jmp_branch_valid:
    - pc_out += 4 and rd_offset++;
    - if rd_offset was 3, it wraps to 0 and rd_ptr++.
  - dispatch_rd_en while empty is ignored (no state change).
- Redirect (jmp_branch_valid=1) takes priority over pop and fill in the same cycle. Next edge:
  - wr_ptr=rd_ptr=0;
  - fetch_pc=target, pc_out=target, rd_offset=target[3:2];
  - the cache line presented that cycle is dropped (abort=1).
  - The first line after a redirect is the aligned line containing the target; dispatch starts at word target[3:2]. Latency from redirect to first valid instruction is 2 edges: flush, then fill.
- Full/pop interaction: a pop from a full queue frees the slot only at the next edge. rd_en stays 0 in that cycle (no same-cycle bypass).
- Simultaneous fill and pop when not full: both are performed; the occupancy count is unchanged if the pop consumed the last word of a line.
- Wrap-around: pointers wrap modulo 2*IFQ_DEPTH. fetch_pc wraps naturally at 32 bits; there is no special handling.
- Throughput: one line per cycle fill, one instruction per cycle dispatch.

Test Plan:
1. Reset release, cache model returns line L0=128'h00000004_00000003_00000002_00000001 for PC 0x0040_0000:
   - after 1 edge: empty=0, instr_out=0x00000001, pc_out=0x0040_0000, PC_in=0x0040_0010.
2. Hold dispatch_rd_en=0 with valid lines:
   - after 4 fills full=1, rd_en=0, PC_in frozen at 0x0040_0040.
   - one pop → full stays 1 until the 4th word of the line is popped; rd_en=1 one cycle after the line frees.
3. Pop 4 times from L0:
   - instr_out sequence 1,2,3,4; pc_out 0x0040_0000..0x0040_000C;
   - rd_ptr advances after the 4th pop; the next pop shows word 0 of the next line, pc_out=0x0040_0010.
4. jmp_branch_valid=1, jmp_branch_address=0x0040_00F8, with concurrent dispatch_rd_en=1 and d_out_valid=1:
   - same cycle: abort=1.
   - next edge: empty=1, PC_in=0x0040_00F8, pc_out=0x0040_00F8.
   - after fill: instr_out = word 2 of line 15, then word 3, then line 0x0040_0100 word 0.
5. Pop while empty (dispatch_rd_en=1, d_out_valid=0): pc_out, pointers and empty unchanged.
6. Assert rst_n=0 asynchronously mid-fill with 3 lines queued: outputs return to reset values before the next clock edge; PC_in=0x0040_0000.
